// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS datapath: write-back select
// encodings, default widths and the hard-wired zero register.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/wb_select.sv
// Combinational write-back value select (ALU result, load data or link
// address). Kept standalone so the forwarding path can reuse it.
module wb_select
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] link_addr,
    output logic [DATA_W-1:0] wb_data
);

    // Pick the write-back source; the reserved encoding falls back to the ALU result
    always_comb begin
        wb_data = alu_result;
        case (wb_sel_e'(sel))
            WB_SEL_MEM:  wb_data = mem_data;
            WB_SEL_LINK: wb_data = link_addr;
            default:     wb_data = alu_result;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select and register file write
// port. The retired-instruction counter is only built when the macro
// MEMWB_RETIRE_CNT_EN is defined; otherwise retire_cnt_o is tied to zero.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic [1:0]        MemtoReg_i,
    input  logic [DATA_W-1:0] ALUresult_i,
    input  logic [DATA_W-1:0] MemData_i,
    input  logic [DATA_W-1:0] PCplus4_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    logic              valid_q;
    logic              regwrite_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] wb_data;
    logic              load_en;

    // Selecting before the register keeps MEM-to-WB latency at one cycle
    wb_select #(.DATA_W(DATA_W)) u_wb_select (
        .sel        (MemtoReg_i),
        .alu_result (ALUresult_i),
        .mem_data   (MemData_i),
        .link_addr  (PCplus4_i),
        .wb_data    (wb_data)
    );

    assign load_en = !flush_i && !stall_i;

    // Pipeline register: flush inserts a bubble, stall holds, otherwise capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else if (flush_i) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else if (!stall_i) begin
            valid_q    <= valid_i;
            regwrite_q <= RegWrite_i & valid_i;
            addr_q     <= RDaddr_i;
            data_q     <= wb_data;
        end
    end

    // $0 is hard-wired, so its writes are dropped here while address/data stay visible
    assign RegWrite_o = regwrite_q & valid_q & (addr_q != ADDR_W'(REG_ZERO));
    assign RDaddr_o   = addr_q;
    assign RDdata_o   = data_q;
    assign valid_o    = valid_q;

`ifdef MEMWB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count each real instruction once, on the edge it enters WB; wraps freely
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_en && valid_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt_o = cnt_q;
`else
    assign retire_cnt_o = '0;
`endif

endmodule
